// File: rtl/adc_packet_receiver.sv
// adc_packet_receiver
// Locks onto the free-running ADC packet stream (header, NWORDS payload words,
// footer), validates each footer, stores good frames in a two-bank ping-pong
// buffer and replays the payload on a valid/ready stream.
// Optional build macro ADC_PKT_SEQ_EN: prefix each emitted frame with a
// {16'h5EC0, seq} word, where seq counts every good footer (drops included).
module adc_packet_receiver #(
  parameter int          NWORDS = 24,
  parameter logic [31:0] HEADER = 32'hAAAAAAAA,
  parameter logic [31:0] FOOTER = 32'hF0F0F0F0,
  parameter int          CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      DATA_IN,
  output logic [31:0]      DOUT,
  output logic             DOUT_VALID,
  output logic             DOUT_LAST,
  input  logic             DOUT_READY,
  output logic             LOCKED,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] DROP_CNT
);

  localparam int IW = $clog2(NWORDS);
  localparam int AW = $clog2(2 * NWORDS);
`ifdef ADC_PKT_SEQ_EN
  localparam int FRAME_LEN = NWORDS + 1;
`else
  localparam int FRAME_LEN = NWORDS;
`endif
  localparam int RW = $clog2(FRAME_LEN);

  localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);
  localparam logic [RW-1:0] PTR_LAST = RW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] BANK1_BASE = AW'(NWORDS);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_FOOTER  = 2'd2
  } state_t;

  // Saturating increment for the status counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Write side state
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           wr_bank_q, wr_bank_d;
  logic           scratch_q, scratch_d;
  logic [1:0]     full_q, full_d;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic           footer_ok;
  logic           footer_bad;
  logic           commit;
  logic           drop;
  logic [1:0]     full_free;

  // Read side state
  logic [RW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           rd_bank_q, rd_bank_d;
  logic [31:0]    dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           load;
  logic [1:0]     rd_free;
  logic [RW-1:0]  rd_idx;
  logic [AW-1:0]  rd_addr;
  logic [31:0]    rd_word;

  // Status
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Frame storage: bank 0 at [0, NWORDS), bank 1 at [NWORDS, 2*NWORDS)
  logic [31:0] mem_q [2*NWORDS];

`ifdef ADC_PKT_SEQ_EN
  logic [15:0] seq_q;
  logic [15:0] bank_seq_q [2];
`endif

  // A bank being released by the reader this cycle already counts as free
  assign full_free = full_q & ~rd_free;

  // Write FSM next-state: hunt for header, capture payload, check footer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scratch_d  = scratch_q;
    wr_en      = 1'b0;
    footer_ok  = 1'b0;
    footer_bad = 1'b0;
    unique case (state_q)
      S_HUNT: begin
        if (DATA_IN == HEADER) begin
          state_d   = S_PAYLOAD;
          idx_d     = '0;
          // A still-occupied target bank diverts the frame to scratch
          scratch_d = full_free[wr_bank_q];
        end
      end
      S_PAYLOAD: begin
        wr_en = ~scratch_q;
        idx_d = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_FOOTER;
        end
      end
      S_FOOTER: begin
        state_d = S_HUNT;
        if (DATA_IN == FOOTER) begin
          footer_ok = 1'b1;
        end else begin
          footer_bad = 1'b1;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  assign commit  = footer_ok & ~scratch_q & ~full_free[wr_bank_q];
  assign drop    = footer_ok & ~commit;
  assign wr_addr = AW'(idx_q) + (wr_bank_q ? BANK1_BASE : AW'(0));

  // Bank bookkeeping: reader releases, writer commits and flips banks
  always_comb begin
    full_d    = full_free;
    wr_bank_d = wr_bank_q;
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
  end

  // Write FSM and bank state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_HUNT;
      idx_q     <= '0;
      scratch_q <= 1'b0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      scratch_q <= scratch_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
    end
  end

  // Payload storage write
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= DATA_IN;
    end
  end

`ifdef ADC_PKT_SEQ_EN
  // Sequence number advances on every good footer, committed or dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      seq_q <= '0;
    end else if (footer_ok) begin
      seq_q <= seq_q + 16'd1;
    end
  end

  // Sequence number travels with the bank it was committed to
  always_ff @(posedge CLK) begin
    if (commit) begin
      bank_seq_q[wr_bank_q] <= seq_q;
    end
  end
`endif

  // Read address: with the prefix word, pointer 0 is the prefix
  always_comb begin
`ifdef ADC_PKT_SEQ_EN
    rd_idx = (rd_ptr_q == '0) ? '0 : rd_ptr_q - RW'(1);
`else
    rd_idx = rd_ptr_q;
`endif
    rd_addr = AW'(rd_idx) + (rd_bank_q ? BANK1_BASE : AW'(0));
  end

  // Select the next outgoing word from storage (or the prefix)
  always_comb begin
    rd_word = mem_q[rd_addr];
`ifdef ADC_PKT_SEQ_EN
    if (rd_ptr_q == '0) begin
      rd_word = {16'h5EC0, bank_seq_q[rd_bank_q]};
    end
`endif
  end

  // Output stage may advance when empty or when the current word transfers
  always_comb begin
    load     = (~valid_q | DOUT_READY) & full_q[rd_bank_q];
    rd_free  = 2'b00;
    rd_ptr_d = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (load) begin
      dout_d  = rd_word;
      valid_d = 1'b1;
      last_d  = (rd_ptr_q == PTR_LAST);
      if (rd_ptr_q == PTR_LAST) begin
        rd_ptr_d           = '0;
        rd_bank_d          = ~rd_bank_q;
        rd_free[rd_bank_q] = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + RW'(1);
      end
    end else if (DOUT_READY) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Read-side registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_bank_q <= rd_bank_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  // Status next-state: lock flag and saturating counters
  always_comb begin
    locked_d    = locked_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (footer_ok) begin
      locked_d = 1'b1;
    end else if (footer_bad) begin
      locked_d = 1'b0;
    end
    if (commit) begin
      frame_cnt_d = sat_inc(frame_cnt_q);
    end
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    if (footer_bad) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      locked_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      locked_q    <= locked_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
  assign DOUT_LAST  = last_q;
  assign LOCKED     = locked_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign ERR_CNT    = err_cnt_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_adc_packet_receiver.sv
// Scoreboard bench for adc_packet_receiver: stimulus pushes expected output
// words into a queue, an independent monitor pops and compares on transfers.
module tb_adc_packet_receiver;

  localparam int          NW  = 24;
  localparam logic [31:0] HDR = 32'hAAAAAAAA;
  localparam logic [31:0] FTR = 32'hF0F0F0F0;

  logic        CLK;
  logic        RST;
  logic [31:0] DATA_IN;
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_LAST;
  logic        DOUT_READY;
  logic        LOCKED;
  logic [15:0] FRAME_CNT;
  logic [15:0] ERR_CNT;
  logic [15:0] DROP_CNT;

  adc_packet_receiver dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_LAST  (DOUT_LAST),
    .DOUT_READY (DOUT_READY),
    .LOCKED     (LOCKED),
    .FRAME_CNT  (FRAME_CNT),
    .ERR_CNT    (ERR_CNT),
    .DROP_CNT   (DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pops     = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_seq  = '0;
  bit          toggle_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pop and compare on every transfer, and check stall stability
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  always @(negedge CLK) begin
    logic [32:0] e;
    if (RST === 1'b1) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(DOUT_VALID), 64'd1);
        chk("stall_dout", 64'(DOUT), 64'(prev_d));
        chk("stall_last", 64'(DOUT_LAST), 64'(prev_l));
      end
      if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b1) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(DOUT), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("dout_word", 64'(DOUT), 64'(e[31:0]));
          chk("dout_last", 64'(DOUT_LAST), 64'(e[32]));
        end
      end
      stall_prev = (DOUT_VALID === 1'b1) && (DOUT_READY === 1'b0);
      prev_d     = DOUT;
      prev_l     = DOUT_LAST;
    end
  end

  task automatic put(input logic [31:0] w);
    @(posedge CLK);
    #1;
    DATA_IN = w;
    if (toggle_en) DOUT_READY = ~DOUT_READY;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(32'h0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    DATA_IN = 32'h0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    exp_seq = '0;
  endtask

  task automatic send_frame(input int fid, input logic [31:0] ftr, input bit expect_out);
    logic [31:0] w;
    put(HDR);
`ifdef ADC_PKT_SEQ_EN
    if (expect_out) exp_q.push_back({1'b0, 16'h5EC0, exp_seq});
`endif
    for (int k = 0; k < NW; k++) begin
      w = {16'(fid), 16'(k)};
      put(w);
      if (expect_out) exp_q.push_back({(k == NW - 1), w});
    end
    put(ftr);
    if (ftr == FTR) exp_seq++;
  endtask

  task automatic chk_cnts(input string t, input int f, input int e, input int d);
    chk({t, "_frame_cnt"}, 64'(FRAME_CNT), 64'(f));
    chk({t, "_err_cnt"}, 64'(ERR_CNT), 64'(e));
    chk({t, "_drop_cnt"}, 64'(DROP_CNT), 64'(d));
  endtask

  initial begin
    int base;
    RST = 1'b1;
    DATA_IN = 32'h0;
    DOUT_READY = 1'b1;

    // Reset state
    do_reset();
    chk("rst_dout", 64'(DOUT), 64'd0);
    chk("rst_valid", 64'(DOUT_VALID), 64'd0);
    chk("rst_last", 64'(DOUT_LAST), 64'd0);
    chk("rst_locked", 64'(LOCKED), 64'd0);
    chk_cnts("rst", 0, 0, 0);

    // 1: three back-to-back clean frames
    for (int f = 1; f <= 3; f++) send_frame(f, FTR, 1'b1);
    idle(60);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);
    chk_cnts("t1", 3, 0, 0);
    chk("t1_locked", 64'(LOCKED), 64'd1);

    // 2: stream joins mid-frame at payload word 10
    do_reset();
    for (int k = 10; k < NW; k++) put({16'd0, 16'(k)});
    put(FTR);
    send_frame(1, FTR, 1'b1);
    idle(40);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);
    chk_cnts("t2", 1, 0, 0);

    // 3: middle frame has a corrupted footer
    do_reset();
    send_frame(1, FTR, 1'b1);
    idle(1);
    chk("t3_locked_f1", 64'(LOCKED), 64'd1);
    send_frame(2, 32'hF0F0F0F1, 1'b0);
    idle(1);
    chk("t3_locked_f2", 64'(LOCKED), 64'd0);
    chk("t3_err_f2", 64'(ERR_CNT), 64'd1);
    send_frame(3, FTR, 1'b1);
    idle(1);
    chk("t3_locked_f3", 64'(LOCKED), 64'd1);
    idle(40);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);
    chk_cnts("t3", 2, 1, 0);

    // 4: downstream stalled over four frames
    do_reset();
    DOUT_READY = 1'b0;
    send_frame(1, FTR, 1'b1);
    send_frame(2, FTR, 1'b1);
    send_frame(3, FTR, 1'b0);
    send_frame(4, FTR, 1'b0);
    idle(2);
    chk_cnts("t4", 2, 0, 2);
    DOUT_READY = 1'b1;
    idle(80);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: READY toggling every cycle, idle gaps between frames
    do_reset();
    toggle_en = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      send_frame(f, FTR, 1'b1);
      idle(30);
    end
    idle(150);
    toggle_en = 1'b0;
    DOUT_READY = 1'b1;
    idle(2);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    chk_cnts("t5", 3, 0, 0);

    // 6: reset pulsed in the middle of a drain
    do_reset();
    base = pops;
    send_frame(1, FTR, 1'b1);
    for (int i = 0; i < 200 && pops < base + 12; i++) put(32'h0);
    chk("t6_reached_word12", 64'(pops >= base + 12), 64'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    DATA_IN = 32'h0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    exp_seq = '0;
    chk("t6_valid_after_rst", 64'(DOUT_VALID), 64'd0);
    chk("t6_locked_after_rst", 64'(LOCKED), 64'd0);
    chk_cnts("t6_rst", 0, 0, 0);
    send_frame(2, FTR, 1'b1);
    idle(40);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);
    chk_cnts("t6", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
